// File: rtl/pe_route_arbiter.sv
// pe_route_arbiter: round-robin merge of the west/north/south links onto one registered east link.
// Latency: a valid input seen in ARB at cycle N is granted at N+1 and appears on out_to_east at N+2.
// Backpressure: the granted input is consumed only when the east register is free (empty or east_ready).
// Ports:
//   clk, reset        - single rising-edge clock, synchronous active-high reset
//   ap_start          - enable, sampled only while idle
//   in_from_<dir>     - inbound link words {valid, last, payload}
//   ready_to_<dir>    - combinational "word consumed this cycle" strobes
//   out_to_east       - registered east link word; east_ready accepts it
//   pkt_count         - packets accepted downstream (wraps)
//   overrun           - sticky flag, set when a packet was cut at MAX_BEATS
module pe_route_arbiter #(
  parameter int WIDTH     = 130,
  parameter int MAX_BEATS = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [WIDTH-1:0]     in_from_west,
  input  logic [WIDTH-1:0]     in_from_north,
  input  logic [WIDTH-1:0]     in_from_south,
  output logic                 ready_to_west,
  output logic                 ready_to_north,
  output logic                 ready_to_south,
  output logic [WIDTH-1:0]     out_to_east,
  input  logic                 east_ready,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 overrun
);

  localparam int VB = WIDTH - 1;  // valid bit
  localparam int LB = WIDTH - 2;  // last bit
  localparam logic [7:0] MAX_B = MAX_BEATS[7:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic [2:0]       in_vld;
  logic [WIDTH-1:0] sel_word;
  logic             sel_vld;
  logic             sel_last;
  logic             out_free;
  logic             xfer;
  logic [7:0]       beat_next;
  logic             hit_max;
  logic             grant_release;
  logic             forced;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [2:0]       rr_sum;
  logic [1:0]       rr_idx;

  assign in_vld = {in_from_south[VB], in_from_north[VB], in_from_west[VB]};

  always_comb begin
    sel_word = in_from_west;
    case (grant_q)
      2'd1:    sel_word = in_from_north;
      2'd2:    sel_word = in_from_south;
      default: sel_word = in_from_west;
    endcase
  end

  assign sel_vld  = sel_word[VB];
  assign sel_last = sel_word[LB];

  // The register can take a new word when it is empty or its word leaves this cycle.
  assign out_free = ~out_to_east[VB] | east_ready;
  assign xfer     = (state_q == S_BURST) & sel_vld & out_free;

  assign beat_next     = beat_cnt_q + 8'd1;
  assign hit_max       = (beat_next == MAX_B);
  assign grant_release = xfer & (sel_last | hit_max);
  // Cut packet: the tail re-arbitrates later as a fresh packet.
  assign forced        = xfer & ~sel_last & hit_max;

  assign ready_to_west  = xfer & (grant_q == 2'd0);
  assign ready_to_north = xfer & (grant_q == 2'd1);
  assign ready_to_south = xfer & (grant_q == 2'd2);

  // Round-robin search starting at rr_ptr; only inputs presenting valid are eligible.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    rr_sum     = 3'd0;
    rr_idx     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + 3'(k);
      rr_idx = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
      if (!pick_found && in_vld[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = 8'd0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (xfer) beat_cnt_d = beat_next;
        if (grant_release) begin
          state_d  = S_ARB;
          rr_ptr_d = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_to_east <= '0;
    end else if (xfer) begin
      out_to_east <= {1'b1, sel_last | hit_max, sel_word[WIDTH-3:0]};
    end else if (east_ready) begin
      out_to_east[VB] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
      overrun   <= 1'b0;
    end else begin
      if (out_to_east[VB] && out_to_east[LB] && east_ready)
        pkt_count <= pkt_count + 1'b1;
      if (forced)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_route_arbiter.sv
// Directed bench for pe_route_arbiter: queued source words, captured east words, hand-computed expectations.
module tb_pe_route_arbiter;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ap_start = 1'b0;
  logic [W-1:0] in_from_west = '0;
  logic [W-1:0] in_from_north = '0;
  logic [W-1:0] in_from_south = '0;
  logic         ready_to_west, ready_to_north, ready_to_south;
  logic [W-1:0] out_to_east;
  logic         east_ready = 1'b1;
  logic [3:0]   pkt_count;
  logic         overrun;

  pe_route_arbiter #(.WIDTH(W), .MAX_BEATS(4), .CNT_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ap_start       (ap_start),
    .in_from_west   (in_from_west),
    .in_from_north  (in_from_north),
    .in_from_south  (in_from_south),
    .ready_to_west  (ready_to_west),
    .ready_to_north (ready_to_north),
    .ready_to_south (ready_to_south),
    .out_to_east    (out_to_east),
    .east_ready     (east_ready),
    .pkt_count      (pkt_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int st_lo = 1000;
  int st_hi = 0;

  logic [8:0] q_w[$], q_n[$], q_s[$];   // {last, payload}
  logic [8:0] cap[$];
  int         cap_cyc[$];
  logic [W-1:0] h_out [0:127];
  logic         h_rw [0:127];
  logic         h_rn [0:127];
  logic         h_rs [0:127];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    in_from_west  = (q_w.size() > 0) ? {1'b1, q_w[0]} : '0;
    in_from_north = (q_n.size() > 0) ? {1'b1, q_n[0]} : '0;
    in_from_south = (q_s.size() > 0) ? {1'b1, q_s[0]} : '0;
    east_ready    = !(cyc >= st_lo && cyc <= st_hi);
  endtask

  // One clock: sample mid-cycle, pop whatever the DUT consumed at the edge, re-drive.
  task automatic step();
    logic rw, rn, rs;
    @(negedge clk);
    rw = ready_to_west; rn = ready_to_north; rs = ready_to_south;
    if (cyc < 128) begin
      h_out[cyc] = out_to_east;
      h_rw[cyc]  = rw;
      h_rn[cyc]  = rn;
      h_rs[cyc]  = rs;
    end
    if (out_to_east[W-1] && east_ready) begin
      cap.push_back(out_to_east[8:0]);
      cap_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    ap_start = 1'b0;
    if (rw && q_w.size() > 0) void'(q_w.pop_front());
    if (rn && q_n.size() > 0) void'(q_n.pop_front());
    if (rs && q_s.size() > 0) void'(q_s.pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ap_start = 1'b0;
    q_w.delete(); q_n.delete(); q_s.delete();
    st_lo = 1000; st_hi = 0; cyc = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cap.delete(); cap_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    int t0;
    int ncap;
    logic any;
    logic [8:0] exp_rr [0:11];

    // Reset state and IDLE holding off a valid input
    do_reset();
    check_eq("rst_out", 32'(out_to_east), 32'h0);
    check_eq("rst_rdy", {29'd0, ready_to_west, ready_to_north, ready_to_south}, 32'h0);
    check_eq("rst_pkt", 32'(pkt_count), 32'h0);
    check_eq("rst_ovr", 32'(overrun), 32'h0);
    q_w = '{9'h010, 9'h011, 9'h112};
    drive();
    repeat (4) step();
    any = h_rw[0] | h_rw[1] | h_rw[2] | h_rw[3];
    check_eq("idle_no_rdy", 32'(any), 32'h0);
    check_eq("idle_no_out", cap.size(), 0);

    // Single packet: out valid three cycles after ap_start, beats back to back
    t0 = cyc;
    ap_start = 1'b1;
    repeat (8) step();
    check_eq("sp_count", cap.size(), 3);
    check_eq("sp_b0", 32'(cap[0]), 32'h010);
    check_eq("sp_b1", 32'(cap[1]), 32'h011);
    check_eq("sp_b2", 32'(cap[2]), 32'h112);
    check_eq("sp_lat", cap_cyc[0] - t0, 3);
    check_eq("sp_tput", cap_cyc[2] - cap_cyc[0], 2);
    check_eq("sp_pkt", 32'(pkt_count), 32'h1);

    // Round-robin: three inputs, two 2-beat packets each
    do_reset();
    q_w = '{9'h010, 9'h111, 9'h012, 9'h113};
    q_n = '{9'h020, 9'h121, 9'h022, 9'h123};
    q_s = '{9'h030, 9'h131, 9'h032, 9'h133};
    exp_rr = '{9'h010, 9'h111, 9'h020, 9'h121, 9'h030, 9'h131,
               9'h012, 9'h113, 9'h022, 9'h123, 9'h032, 9'h133};
    drive();
    ap_start = 1'b1;
    repeat (22) step();
    check_eq("rr_count", cap.size(), 12);
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("rr_w%0d", i), 32'(cap[i]), 32'(exp_rr[i]));
    check_eq("rr_b2b", cap_cyc[1] - cap_cyc[0], 1);
    check_eq("rr_bubble", cap_cyc[2] - cap_cyc[1], 2);
    check_eq("rr_rdy_w", 32'(h_rw[2]), 32'h1);
    check_eq("rr_rdy_n_lose", 32'(h_rn[2]), 32'h0);
    check_eq("rr_rdy_s_lose", 32'(h_rs[2]), 32'h0);
    check_eq("rr_pkt", 32'(pkt_count), 32'h6);

    // Backpressure: east_ready low on burst cycles 2..4 (absolute cycles 3..5)
    do_reset();
    q_n = '{9'h020, 9'h021, 9'h022, 9'h123};
    st_lo = 3; st_hi = 5;
    drive();
    ap_start = 1'b1;
    repeat (12) step();
    check_eq("bp_count", cap.size(), 4);
    check_eq("bp_b0", 32'(cap[0]), 32'h020);
    check_eq("bp_b1", 32'(cap[1]), 32'h021);
    check_eq("bp_b2", 32'(cap[2]), 32'h022);
    check_eq("bp_b3", 32'(cap[3]), 32'h123);
    check_eq("bp_first_acc", cap_cyc[0], 6);
    for (int c = 3; c <= 5; c++) begin
      check_eq($sformatf("bp_hold%0d", c), 32'(h_out[c]), 32'h220);
      check_eq($sformatf("bp_rdy%0d", c), 32'(h_rn[c]), 32'h0);
    end
    check_eq("bp_rdy_resume", 32'(h_rn[6]), 32'h1);
    check_eq("bp_pkt", 32'(pkt_count), 32'h1);

    // Forced release at MAX_BEATS=4 on a 6-beat south packet
    do_reset();
    q_s = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034, 9'h135};
    drive();
    ap_start = 1'b1;
    repeat (14) step();
    check_eq("fr_count", cap.size(), 6);
    check_eq("fr_b2", 32'(cap[2]), 32'h032);
    check_eq("fr_cut", 32'(cap[3]), 32'h133);
    check_eq("fr_b4", 32'(cap[4]), 32'h034);
    check_eq("fr_b5", 32'(cap[5]), 32'h135);
    check_eq("fr_gap", cap_cyc[4] - cap_cyc[3], 2);
    check_eq("fr_ovr", 32'(overrun), 32'h1);
    check_eq("fr_pkt", 32'(pkt_count), 32'h2);

    // Reset during beat 2 of a west packet
    do_reset();
    q_w = '{9'h010, 9'h011, 9'h112};
    drive();
    ap_start = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("mr_out", 32'(out_to_east), 32'h0);
    check_eq("mr_rdy", 32'(ready_to_west), 32'h0);
    check_eq("mr_pkt", 32'(pkt_count), 32'h0);
    ncap = cap.size();
    t0 = cyc;
    repeat (5) step();
    any = 1'b0;
    for (int c = t0; c < t0 + 5; c++) any = any | h_rw[c] | h_out[c][W-1];
    check_eq("mr_quiet", 32'(any), 32'h0);
    check_eq("mr_no_cap", cap.size(), ncap);
    ap_start = 1'b1;
    repeat (6) step();
    check_eq("mr_restart", 32'(cap[cap.size()-1]), 32'h112);
    check_eq("mr_restart_pkt", 32'(pkt_count), 32'h1);

    // Counter wrap: 17 one-beat packets with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) q_w.push_back(9'(9'h100 + i));
    drive();
    ap_start = 1'b1;
    repeat (40) step();
    check_eq("wr_count", cap.size(), 17);
    check_eq("wr_last", 32'(cap[16]), 32'h110);
    check_eq("wr_pkt", 32'(pkt_count), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
